// File: rtl/vga_line_fetch_scheduler.sv
// Schedules one framebuffer line fetch per horizontal blank into a ping-pong line buffer.
// Also tracks fetch overruns (underrun), the scan-out bank and the frame-start strobe.
module vga_line_fetch_scheduler #(
    parameter int H_ACTIVE       = 800,
    parameter int V_ACTIVE       = 480,
    parameter int FRAME          = 499,
    parameter int WORDS_PER_LINE = 100,
    parameter int BASE_ADDR      = 0,
    parameter int ADDR_W         = 16
) (
    input  logic              pixel_clk,
    input  logic              rst_pixel,
    input  logic              en,
    input  logic [9:0]        sx,
    input  logic [9:0]        sy,
    output logic              req_valid,
    input  logic              req_ready,
    output logic [ADDR_W-1:0] req_addr,
    output logic [9:0]        req_line,
    output logic              req_buf,
    input  logic              fill_done,
    output logic              rd_buf,
    output logic              frame_start,
    output logic              busy,
    output logic              underrun,
    input  logic              underrun_clr
);

    localparam int PW = ADDR_W + 10;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t          state;
    logic [9:0]      target;
    logic            trig;
    logic            trig_ok;
    logic [PW-1:0]   addr_full;

    // The fetch for line N+1 is launched at the start of line N's horizontal blank.
    always_comb begin
        target    = (sy == 10'(FRAME)) ? 10'd0 : sy + 10'd1;
        trig      = en && (sx == 10'(H_ACTIVE));
        trig_ok   = trig && (target < 10'(V_ACTIVE));
        addr_full = PW'(BASE_ADDR) + PW'(target) * PW'(WORDS_PER_LINE);
    end

    assign busy = (state != IDLE);

    always_ff @(posedge pixel_clk or posedge rst_pixel) begin
        if (rst_pixel) begin
            state       <= IDLE;
            req_valid   <= 1'b0;
            req_addr    <= '0;
            req_line    <= '0;
            req_buf     <= 1'b0;
            rd_buf      <= 1'b0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            rd_buf      <= sy[0];
            frame_start <= (sx == 10'd0) && (sy == 10'd0);

            case (state)
                IDLE: begin
                    if (trig_ok) begin
                        req_line  <= target;
                        req_buf   <= target[0];
                        req_addr  <= addr_full[ADDR_W-1:0];
                        req_valid <= 1'b1;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    if (req_ready) begin
                        req_valid <= 1'b0;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (fill_done)
                        state <= IDLE;
                end
                default: begin
                    req_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase

            // A trigger that arrives while a fetch is still in flight is dropped; set beats clear.
            if (trig_ok && state != IDLE)
                underrun <= 1'b1;
            else if (underrun_clr)
                underrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_line_fetch_scheduler.sv
// Directed bench for vga_line_fetch_scheduler: single-line fetches, wrap, blanking,
// underrun, async reset and a full frame against a 50-cycle memory model.
module tb_vga_line_fetch_scheduler;

    logic        pixel_clk = 1'b0;
    logic        rst_pixel = 1'b1;
    logic        en = 1'b0;
    logic [9:0]  sx = 10'd0;
    logic [9:0]  sy = 10'd1;
    logic        req_valid;
    logic        req_ready = 1'b0;
    logic [15:0] req_addr;
    logic [9:0]  req_line;
    logic        req_buf;
    logic        fill_done = 1'b0;
    logic        rd_buf;
    logic        frame_start;
    logic        busy;
    logic        underrun;
    logic        underrun_clr = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    // memory model / frame bookkeeping
    bit mem_on = 1'b0;
    bit fs_on  = 1'b0;
    int lat    = 0;
    int n_req  = 0;
    int fs_cnt = 0;

    vga_line_fetch_scheduler dut (
        .pixel_clk   (pixel_clk),
        .rst_pixel   (rst_pixel),
        .en          (en),
        .sx          (sx),
        .sy          (sy),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_line    (req_line),
        .req_buf     (req_buf),
        .fill_done   (fill_done),
        .rd_buf      (rd_buf),
        .frame_start (frame_start),
        .busy        (busy),
        .underrun    (underrun),
        .underrun_clr(underrun_clr)
    );

    always #5 pixel_clk = ~pixel_clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Memory: accept one cycle after req_valid is seen, fill_done 50 cycles after the handshake.
    task automatic mem_tick();
        if (fill_done) fill_done = 1'b0;
        if (req_ready) begin
            req_ready = 1'b0;
            lat = 50;
        end else if (lat > 0) begin
            lat--;
            if (lat == 0) fill_done = 1'b1;
        end else if (req_valid) begin
            chk("frame_line", 32'(req_line), 32'(n_req));
            chk("frame_addr", 32'(req_addr), 32'(n_req * 100));
            req_ready = 1'b1;
            n_req++;
        end
    endtask

    task automatic step();
        @(posedge pixel_clk);
        #1;
        if (fs_on && frame_start) fs_cnt++;
        if (mem_on) mem_tick();
    endtask

    initial begin
        // 1: reset
        repeat (5) step();
        rst_pixel = 1'b0;
        chk("rst_valid", 32'(req_valid), 0);
        chk("rst_addr", 32'(req_addr), 0);
        chk("rst_line", 32'(req_line), 0);
        chk("rst_buf", 32'(req_buf), 0);
        chk("rst_rdbuf", 32'(rd_buf), 0);
        chk("rst_fs", 32'(frame_start), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_underrun", 32'(underrun), 0);

        // 2: normal fetch of line 11
        en = 1'b1; sy = 10'd10; sx = 10'd799;
        step();
        chk("rd_buf_even", 32'(rd_buf), 0);
        sx = 10'd800;
        chk("pre_trig_valid", 32'(req_valid), 0);
        step();
        sx = 10'd801;
        chk("n_valid", 32'(req_valid), 1);
        chk("n_line", 32'(req_line), 11);
        chk("n_buf", 32'(req_buf), 1);
        chk("n_addr", 32'(req_addr), 1100);
        chk("n_busy", 32'(busy), 1);
        repeat (3) step();
        chk("n_hold_valid", 32'(req_valid), 1);
        chk("n_hold_addr", 32'(req_addr), 1100);
        req_ready = 1'b1;
        step();
        req_ready = 1'b0;
        chk("n_hs_valid", 32'(req_valid), 0);
        chk("n_wait_busy", 32'(busy), 1);
        sy = 10'd11;
        repeat (2) step();
        chk("rd_buf_odd", 32'(rd_buf), 1);
        chk("n_wait_busy2", 32'(busy), 1);
        fill_done = 1'b1;
        step();
        fill_done = 1'b0;
        chk("n_done_busy", 32'(busy), 0);

        // 3: wrap, last visible line and blanking
        sy = 10'd499; sx = 10'd800;
        step();
        sx = 10'd801;
        chk("w_valid", 32'(req_valid), 1);
        chk("w_line", 32'(req_line), 0);
        chk("w_addr", 32'(req_addr), 0);
        chk("w_buf", 32'(req_buf), 0);
        req_ready = 1'b1; step(); req_ready = 1'b0;
        fill_done = 1'b1; step(); fill_done = 1'b0;
        chk("w_done_busy", 32'(busy), 0);
        sy = 10'd478; sx = 10'd800;
        step();
        sx = 10'd801;
        chk("l479_line", 32'(req_line), 479);
        chk("l479_addr", 32'(req_addr), 47900);
        req_ready = 1'b1; step(); req_ready = 1'b0;
        fill_done = 1'b1; step(); fill_done = 1'b0;
        sy = 10'd479; sx = 10'd800;
        step();
        sx = 10'd801;
        chk("b479_valid", 32'(req_valid), 0);
        chk("b479_busy", 32'(busy), 0);
        sy = 10'd480; sx = 10'd800;
        step();
        sx = 10'd801;
        chk("b480_valid", 32'(req_valid), 0);
        chk("b480_underrun", 32'(underrun), 0);

        // 4: underrun, set-wins, clear, en low
        sy = 10'd20; sx = 10'd800;
        step();
        sx = 10'd801;
        step();
        sy = 10'd21; sx = 10'd800;
        step();
        sx = 10'd801;
        chk("u_set", 32'(underrun), 1);
        chk("u_line", 32'(req_line), 21);
        chk("u_valid", 32'(req_valid), 1);
        sy = 10'd22; sx = 10'd800; underrun_clr = 1'b1;
        step();
        sx = 10'd801;
        chk("u_setwins", 32'(underrun), 1);
        step();
        underrun_clr = 1'b0;
        chk("u_clear", 32'(underrun), 0);
        en = 1'b0; sy = 10'd23; sx = 10'd800;
        step();
        sx = 10'd801;
        chk("u_en_low", 32'(underrun), 0);
        chk("u_en_line", 32'(req_line), 21);
        req_ready = 1'b1; step(); req_ready = 1'b0;
        chk("u_en_hs", 32'(req_valid), 0);
        fill_done = 1'b1; step(); fill_done = 1'b0;
        chk("u_en_done", 32'(busy), 0);
        sy = 10'd30; sx = 10'd800;
        step();
        sx = 10'd801;
        chk("en_low_idle", 32'(req_valid), 0);
        en = 1'b1;

        // 5: async reset in REQ
        sy = 10'd40; sx = 10'd800;
        step();
        sx = 10'd801;
        chk("a_valid", 32'(req_valid), 1);
        #2 rst_pixel = 1'b1;
        #1;
        chk("a_async_valid", 32'(req_valid), 0);
        chk("a_async_busy", 32'(busy), 0);
        step();
        rst_pixel = 1'b0;
        step();
        chk("a_post_busy", 32'(busy), 0);
        chk("a_post_valid", 32'(req_valid), 0);
        chk("a_post_line", 32'(req_line), 0);

        // 6: full frame, starting from the last line of the previous frame
        n_req = 0; fs_cnt = 0; lat = 0;
        mem_on = 1'b1; fs_on = 1'b1;
        for (int l = 0; l < 500; l++) begin
            sy = (l == 0) ? 10'd499 : 10'(l - 1);
            sx = 10'd0;
            step();
            sx = 10'd5;
            repeat (3) step();
            sx = 10'd800;
            step();
            sx = 10'd801;
            repeat (60) step();
        end
        repeat (5) step();
        mem_on = 1'b0; fs_on = 1'b0;
        chk("f_requests", 32'(n_req), 480);
        chk("f_underrun", 32'(underrun), 0);
        chk("f_frame_start", 32'(fs_cnt), 1);
        chk("f_idle", 32'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
